// File: rtl/port_step_pkg.sv
// Shared types and helpers for the port step arbiter and its rotate-priority picker.
package port_step_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  // A single port still needs a one-bit select bus.
  function automatic int selw(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority search: first set request bit at or after ptr, wrapping modulo PORTS.
module rr_pick
  import port_step_pkg::*;
#(
  parameter int PORTS = 4,
  localparam int SELW = selw(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [SELW-1:0]  ptr,
  output logic             found,
  output logic [PORTS-1:0] pick,
  output logic [SELW-1:0]  idx
);

  int cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    cand  = 0;
    for (int i = 0; i < PORTS; i++) begin
      cand = (int'(ptr) + i) % PORTS;
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        idx        = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/port_step_arbiter.sv
// Round-robin arbiter in front of the step sequencer: one grant at a time, start pulse, hold until done.
// Optional watchdog abort of a stuck transaction is compiled in with ARB_TIMEOUT_EN.
module port_step_arbiter
  import port_step_pkg::*;
#(
  parameter int PORTS   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int SELW   = selw(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req,
  output logic [PORTS-1:0] gnt,
  output logic [SELW-1:0]  sel,
  output logic             start,
  input  logic             done,
`ifdef ARB_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic             busy
);

  arb_state_e       state_q, state_d;
  logic [PORTS-1:0] gnt_q, gnt_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             found;
  logic [PORTS-1:0] pick;
  logic [SELW-1:0]  idx;
  logic [SELW-1:0]  next_ptr;
`ifdef ARB_TIMEOUT_EN
  logic [15:0]      cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_pick #(.PORTS(PORTS)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .pick  (pick),
    .idx   (idx)
  );

  assign next_ptr = (sel_q == SELW'(PORTS - 1)) ? '0 : sel_q + SELW'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    start_d = 1'b0;
    busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          sel_d   = idx;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: begin
        // done has priority over the watchdog when both land in the same cycle.
        if (done) begin
          gnt_d   = '0;
          ptr_d   = next_ptr;
          state_d = RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT - 1)) begin
          gnt_d     = '0;
          ptr_d     = next_ptr;
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RELEASE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignment; reset is synchronous and wins over every transition.
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      start_q <= start_d;
      busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign start = start_q;
  assign busy  = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_port_step_arbiter.sv
// Self-checking bench for port_step_arbiter; also exercises the watchdog when ARB_TIMEOUT_EN is defined.
module tb_port_step_arbiter;

  localparam int PORTS = 4;
  localparam int SELW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [PORTS-1:0] req;
  logic [PORTS-1:0] gnt;
  logic [SELW-1:0]  sel;
  logic             start;
  logic             done;
  logic             busy;
  logic             timeout;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  port_step_arbiter #(.PORTS(PORTS), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel), .start(start),
    .done(done), .timeout(timeout), .busy(busy)
  );
`else
  assign timeout = 1'b0;
  port_step_arbiter #(.PORTS(PORTS)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel), .start(start),
    .done(done), .busy(busy)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requesting port at or after the pointer, wrapping around.
  function automatic int model_pick(input logic [PORTS-1:0] r);
    for (int i = 0; i < PORTS; i++) begin
      int c = (mptr + i) % PORTS;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Called at a falling edge while the arbiter is in IDLE; returns at the IDLE falling edge after release.
  task automatic run_txn(input logic [PORTS-1:0] r, input int dly);
    int exp_port;
    int n;
    exp_port = model_pick(r);
    req = r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 16);
    check("grant_latency", 32'(n), 32'd1);
    check("gnt", 32'(gnt), 32'(1 << exp_port));
    check("sel", 32'(sel), 32'(exp_port));
    check("start_on_grant", 32'(start), 32'd1);
    check("busy_on_grant", 32'(busy), 32'd1);
    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      check("start_single", 32'(start), 32'd0);
      check("gnt_held", 32'(gnt), 32'(1 << exp_port));
      if (k == dly) done = 1'b1;
    end
    @(negedge clk);
    done = 1'b0;
    mptr = (exp_port + 1) % PORTS;
    check("release_gnt", 32'(gnt), 32'd0);
    check("release_busy", 32'(busy), 32'd1);
    check("no_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // Single request, done three cycles after start; pointer moves to 3.
    run_txn(4'b0100, 3);
    req = '0;
    @(negedge clk);

    // All ports requesting: expect 3,0,1,2,3 from pointer 3 (model tracks it).
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 1 + (i % 3));
    req = '0;
    @(negedge clk);

    // Put pointer at 1, then 0011 grants port 1 first and 0 after wrap.
    mptr = mptr;
    run_txn(4'b0001, 1);
    run_txn(4'b0011, 2);
    run_txn(4'b0011, 2);

    // done during ISSUE is ignored; dropped request does not release; reset in WAIT clears everything.
    req = 4'b0010;
    @(negedge clk);
    check("issue_gnt", 32'(gnt), 32'b0010);
    done = 1'b1;
    req  = '0;
    @(negedge clk);
    done = 1'b0;
    check("ignore_done_gnt", 32'(gnt), 32'b0010);
    check("ignore_done_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check("drop_req_gnt", 32'(gnt), 32'b0010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    // Pointer back at 0: 0011 must pick port 0.
    run_txn(4'b0011, 1);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    run_txn(4'b1000, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 30; i++) begin
      run_txn(4'($urandom_range(1, 15)), int'($urandom_range(1, 5)));
      if ($urandom_range(0, 1) == 1) begin
        req = '0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("idle_no_grant", 32'(gnt), 32'd0);
      end
    end

`ifdef ARB_TIMEOUT_EN
    // Done on the 8th WAIT cycle wins over the watchdog.
    req = '0;
    @(negedge clk);
    run_txn(4'b1111, 8);
    // No done: watchdog fires after 8 WAIT cycles and the next port follows.
    begin
      int exp_port;
      int n;
      exp_port = model_pick(4'b1111);
      req = 4'b1111;
      @(negedge clk);
      check("wd_gnt", 32'(gnt), 32'(1 << exp_port));
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (timeout == 1'b0 && n < 20);
      check("wd_cycles", 32'(n), 32'd9);
      check("wd_gnt_clear", 32'(gnt), 32'd0);
      mptr = (exp_port + 1) % PORTS;
      @(negedge clk);
      check("wd_pulse", 32'(timeout), 32'd0);
      run_txn(4'b1111, 1);
    end
`endif

    req = '0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
